// File: rtl/dnn_pkg.sv
// Shared encodings, field positions and decoded command layout for the DNN command issue path.
package dnn_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OP_W     = 5;
  localparam int unsigned DATA_W   = 25;
  localparam int unsigned LAYER_W  = 5;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned ADDR_W   = 12;

  localparam logic [1:0] DNN_CLS_CFG = 2'b01;
  localparam logic [1:0] DNN_CLS_RUN = 2'b10;

  localparam int unsigned CLS_LO   = 0;
  localparam int unsigned CLS_HI   = 1;
  localparam int unsigned OP_LO    = 2;
  localparam int unsigned OP_HI    = 6;
  localparam int unsigned DATA_LO  = 7;
  localparam int unsigned DATA_HI  = 31;
  localparam int unsigned LAYER_LO = 7;
  localparam int unsigned LAYER_HI = 11;
  localparam int unsigned LEN_LO   = 12;
  localparam int unsigned LEN_HI   = 19;
  localparam int unsigned ADDR_LO  = 20;
  localparam int unsigned ADDR_HI  = 31;

  typedef enum logic [1:0] {IDLE, CFG, RUN, WAIT_DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [LAYER_W-1:0] layer;
    logic [DATA_W-1:0]  data;
    logic [OP_W-1:0]    op;
  } dnn_cmd_t;

  // Class bits are consumed at dispatch, so only the upper bits are decoded here.
  function automatic dnn_cmd_t dnn_decode(input logic [INSTR_W-1:OP_LO] instr);
    dnn_cmd_t c;
    c.addr  = instr[ADDR_HI:ADDR_LO];
    c.len   = instr[LEN_HI:LEN_LO];
    c.layer = instr[LAYER_HI:LAYER_LO];
    c.data  = instr[DATA_HI:DATA_LO];
    c.op    = instr[OP_HI:OP_LO];
    return c;
  endfunction

endpackage

// File: rtl/dnn_cmd_fifo.sv
// In-order command FIFO; pointers wrap modulo DEPTH, occupancy runs 0..DEPTH.
module dnn_cmd_fifo
  import dnn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [INSTR_W-1:0] wr_data_i,
  output logic [INSTR_W-1:0] rd_data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/dnn_cmd_issue.sv
// Qualifies custom DNN instructions, queues them, and sequences each one to the engine
// as a config handshake or an addressed run burst followed by a bounded wait for done.
module dnn_cmd_issue
  import dnn_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic                instr_en_i,
  output logic                stall_o,
  output logic                cfg_valid_o,
  output logic [OP_W-1:0]     cfg_op_o,
  output logic [DATA_W-1:0]   cfg_data_o,
  input  logic                cfg_ready_i,
  output logic                beat_valid_o,
  output logic [ADDR_W-1:0]   beat_addr_o,
  output logic [LAYER_W-1:0]  beat_layer_o,
  output logic                beat_last_o,
  input  logic                beat_ready_i,
  input  logic                run_done_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t             state_q, state_d;
  dnn_cmd_t           cmd_q, cmd_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               err_q, err_d;

  logic [INSTR_W-1:0] head;
  logic [1:0]         in_cls;
  logic               push_c, pop_c;
  logic               fifo_full, fifo_empty;

  // Only config and run classes enter the queue; stall depends on occupancy alone.
  assign in_cls = instr_i[CLS_HI:CLS_LO];
  assign push_c = instr_en_i & ((in_cls == DNN_CLS_CFG) | (in_cls == DNN_CLS_RUN)) & ~fifo_full;

  dnn_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_c),
    .pop_i     (pop_c),
    .wr_data_i (instr_i),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    pop_c        = 1'b0;
    cfg_valid_o  = 1'b0;
    cfg_op_o     = '0;
    cfg_data_o   = '0;
    beat_valid_o = 1'b0;
    beat_addr_o  = '0;
    beat_layer_o = '0;
    beat_last_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          cmd_d   = dnn_decode(head[INSTR_W-1:OP_LO]);
          cnt_d   = '0;
          state_d = (head[CLS_HI:CLS_LO] == DNN_CLS_CFG) ? CFG : RUN;
        end
      end
      CFG: begin
        cfg_valid_o = 1'b1;
        cfg_op_o    = cmd_q.op;
        cfg_data_o  = cmd_q.data;
        if (cfg_ready_i) state_d = IDLE;
      end
      RUN: begin
        beat_valid_o = 1'b1;
        beat_addr_o  = cmd_q.addr + ADDR_W'(cnt_q);
        beat_layer_o = cmd_q.layer;
        beat_last_o  = (cnt_q == cmd_q.len);
        if (beat_ready_i) begin
          if (cnt_q == cmd_q.len) begin
            state_d = WAIT_DONE;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (run_done_i) begin
          state_d = IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_o = fifo_full;
  assign busy_o  = (state_q != IDLE) | ~fifo_empty;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dnn_cmd_issue.sv
// Directed bench for dnn_cmd_issue: config issue, run bursts, backpressure, timeout and reset abort.
module tb_dnn_cmd_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_i;
  logic        instr_en_i;
  logic        stall_o;
  logic        cfg_valid_o;
  logic [4:0]  cfg_op_o;
  logic [24:0] cfg_data_o;
  logic        cfg_ready_i;
  logic        beat_valid_o;
  logic [11:0] beat_addr_o;
  logic [4:0]  beat_layer_o;
  logic        beat_last_o;
  logic        beat_ready_i;
  logic        run_done_i;
  logic        busy_o;
  logic        err_o;

  int n_pass  = 0;
  int n_total = 0;

  dnn_cmd_issue #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_i      (instr_i),
    .instr_en_i   (instr_en_i),
    .stall_o      (stall_o),
    .cfg_valid_o  (cfg_valid_o),
    .cfg_op_o     (cfg_op_o),
    .cfg_data_o   (cfg_data_o),
    .cfg_ready_i  (cfg_ready_i),
    .beat_valid_o (beat_valid_o),
    .beat_addr_o  (beat_addr_o),
    .beat_layer_o (beat_layer_o),
    .beat_last_o  (beat_last_o),
    .beat_ready_i (beat_ready_i),
    .run_done_i   (run_done_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          k;
    int          idx;
    logic        rdy;
    logic [11:0] exp_addr;

    rst = 1'b1; instr_i = '0; instr_en_i = 1'b0;
    cfg_ready_i = 1'b0; beat_ready_i = 1'b0; run_done_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cfg_valid", cfg_valid_o, 0);
    chk("rst_beat_valid", beat_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;

    // Config command with ready tied high: one valid cycle, two edges after acceptance
    @(negedge clk);
    instr_i = 32'h0000_0085; instr_en_i = 1'b1; cfg_ready_i = 1'b1;
    @(negedge clk);
    instr_en_i = 1'b0;
    chk("cfg_gap_valid", cfg_valid_o, 0);
    chk("cfg_gap_busy", busy_o, 1);
    @(negedge clk);
    chk("cfg_valid", cfg_valid_o, 1);
    chk("cfg_op", cfg_op_o, 32'h01);
    chk("cfg_data", cfg_data_o, 32'h000001);
    @(negedge clk);
    chk("cfg_done_valid", cfg_valid_o, 0);
    chk("cfg_done_busy", busy_o, 0);
    cfg_ready_i = 1'b0;

    // Run burst addr 0x010 len 3 layer 2, ready toggling 1,0,1,...
    instr_i = 32'h0100_3102; instr_en_i = 1'b1; beat_ready_i = 1'b0;
    @(negedge clk);
    instr_en_i = 1'b0;
    chk("run_gap_valid", beat_valid_o, 0);
    @(negedge clk);
    k = 0; rdy = 1'b1;
    for (int i = 0; i < 12 && k < 4; i++) begin
      exp_addr = 12'h010 + 12'(k);
      chk("run_valid", beat_valid_o, 1);
      chk("run_addr", beat_addr_o, exp_addr);
      chk("run_last", beat_last_o, (k == 3));
      chk("run_layer", beat_layer_o, 2);
      beat_ready_i = rdy;
      @(negedge clk);
      if (rdy) k++;
      rdy = ~rdy;
    end
    beat_ready_i = 1'b0;
    chk("run_wait_valid", beat_valid_o, 0);
    chk("run_wait_busy", busy_o, 1);
    repeat (4) begin
      @(negedge clk);
      chk("run_wait_hold", busy_o, 1);
    end
    run_done_i = 1'b1;
    @(negedge clk);
    run_done_i = 1'b0;
    chk("run_done_busy", busy_o, 0);
    chk("run_done_err", err_o, 0);

    // Backpressure: cfg_ready low, push until full, then drain in order
    for (int i = 0; i < 5; i++) begin
      instr_i = (32'(i) << 7) | 32'h0000_0005; instr_en_i = 1'b1;
      chk("fill_stall_low", stall_o, 0);
      @(negedge clk);
    end
    chk("fill_stall_high", stall_o, 1);
    instr_i = (32'd5 << 7) | 32'h0000_0005;
    @(negedge clk);
    chk("fill_stall_hold", stall_o, 1);
    chk("fill_head_valid", cfg_valid_o, 1);
    chk("fill_head_data", cfg_data_o, 0);
    cfg_ready_i = 1'b1;
    @(negedge clk);
    chk("drain_stall_idle", stall_o, 1);
    chk("drain_idle_valid", cfg_valid_o, 0);
    @(negedge clk);
    chk("drain_stall_release", stall_o, 0);
    chk("drain_second_data", cfg_data_o, 1);
    @(negedge clk);
    instr_en_i = 1'b0;
    chk("drain_sixth_accepted", stall_o, 1);
    idx = 2;
    for (int i = 0; i < 20 && idx < 6; i++) begin
      @(negedge clk);
      if (cfg_valid_o) begin
        chk("drain_order", cfg_data_o, 32'(idx));
        idx++;
      end
    end
    chk("drain_count", idx, 6);
    @(negedge clk);
    chk("drain_busy", busy_o, 0);
    cfg_ready_i = 1'b0;

    // Address wrap: 0xFFE, 0xFFF, 0x000
    instr_i = 32'hFFE0_2002; instr_en_i = 1'b1; beat_ready_i = 1'b1;
    @(negedge clk);
    instr_en_i = 1'b0;
    @(negedge clk);
    chk("wrap_addr0", beat_addr_o, 32'hFFE);
    chk("wrap_last0", beat_last_o, 0);
    @(negedge clk);
    chk("wrap_addr1", beat_addr_o, 32'hFFF);
    chk("wrap_last1", beat_last_o, 0);
    @(negedge clk);
    chk("wrap_addr2", beat_addr_o, 32'h000);
    chk("wrap_last2", beat_last_o, 1);
    @(negedge clk);
    chk("wrap_wait_valid", beat_valid_o, 0);
    run_done_i = 1'b1;
    @(negedge clk);
    run_done_i = 1'b0;
    chk("wrap_busy", busy_o, 0);
    chk("wrap_err", err_o, 0);

    // Timeout: run with no done, then a queued config must still issue
    instr_i = 32'h1000_0002; instr_en_i = 1'b1;
    @(negedge clk);
    instr_i = 32'h0000_0285;
    @(negedge clk);
    instr_en_i = 1'b0;
    chk("tmo_beat_valid", beat_valid_o, 1);
    chk("tmo_beat_addr", beat_addr_o, 32'h100);
    chk("tmo_beat_last", beat_last_o, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tmo_err_low", err_o, 0);
      chk("tmo_cfg_held", cfg_valid_o, 0);
    end
    @(negedge clk);
    chk("tmo_err_set", err_o, 1);
    chk("tmo_idle_cfg", cfg_valid_o, 0);
    @(negedge clk);
    chk("tmo_next_valid", cfg_valid_o, 1);
    chk("tmo_next_data", cfg_data_o, 5);
    chk("tmo_next_op", cfg_op_o, 1);
    cfg_ready_i = 1'b1;
    @(negedge clk);
    chk("tmo_busy", busy_o, 0);
    chk("tmo_err_sticky", err_o, 1);
    cfg_ready_i = 1'b0; beat_ready_i = 1'b0;

    // Reset mid-RUN with two commands queued
    instr_i = 32'h2000_7002; instr_en_i = 1'b1;
    @(negedge clk);
    instr_i = 32'h0000_0085;
    @(negedge clk);
    instr_i = 32'h0000_0285;
    chk("abort_run_valid", beat_valid_o, 1);
    @(negedge clk);
    instr_en_i = 1'b0;
    chk("abort_run_hold", beat_valid_o, 1);
    chk("abort_busy_pre", busy_o, 1);
    rst = 1'b1;
    #1;
    chk("abort_beat_valid", beat_valid_o, 0);
    chk("abort_beat_addr", beat_addr_o, 0);
    chk("abort_cfg_valid", cfg_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_stall", stall_o, 0);
    chk("abort_err", err_o, 0);
    @(negedge clk);
    rst = 1'b0; beat_ready_i = 1'b1; cfg_ready_i = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_beat", beat_valid_o, 0);
      chk("post_rst_cfg", cfg_valid_o, 0);
      chk("post_rst_busy", busy_o, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
